truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Self-checking response end for exhaustive combinational tests. Consumes the
//  applied input vector plus the DUT output F, compares F against a golden truth
//  table, and accumulates a pass/fail verdict. It sits downstream of a vector
//  stimulus source and the circuit under test, inside simulation or on-board
//  test harnesses.
// PARAMETERS
//  N_IN      4        number of DUT inputs; 2**N_IN vectors per run
//  EXPECTED  16'h6996 golden table; bit i = expected F for vector i (width 2**N_IN)
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  start          in   1        one-cycle pulse; begins a run
//  sample_valid   in   1        vec/f are valid this cycle
//  vec            in   N_IN     applied input vector, MSB = A ... LSB = D
//  f              in   1        observed DUT output for vec
//  busy           out  1        run in progress
//  done           out  1        run complete; held until next start
//  pass           out  1        valid while done: 1 if zero mismatches and no order error
//  err_count      out  N_IN+1   number of mismatching vectors in this run
//  first_err_idx  out  N_IN     index of first mismatch
//  first_err_vld  out  1        first_err_idx holds a real mismatch
//  order_err      out  1        a sample arrived with vec != expected index
// BEHAVIOUR
//  - Reset: all outputs 0, internal index 0, state IDLE. Reset mid-run aborts it.
//  - FSM: IDLE -start-> RUN; RUN -last sample accepted-> DONE; DONE -start-> RUN.
//    start while in RUN is ignored. No path from DONE back to IDLE except reset.
//  - On entry to RUN (the cycle after start): err_count, first_err_*, order_err,
//    done, pass and idx are cleared. busy=1.
//  - Samples are accepted only in RUN; sample_valid in IDLE or DONE is ignored.
//  - An accepted sample is checked against the internal index idx:
//    mismatch = (f != EXPECTED[vec]); order fault = (vec != idx).
//    On mismatch, err_count increments. If first_err_vld=0, first_err_idx<=vec
//    and first_err_vld<=1. On an order fault, order_err<=1 (sticky per run).
//    idx increments by 1 per accepted sample.
//  - Latency: all result registers reflect a sample one cycle after it is
//    accepted. The accepted sample with idx==2**N_IN-1 moves the FSM to DONE.
//    From the next cycle: busy=0, done=1, and err_count includes the last vector.
//  - pass = done & (err_count==0) & ~order_err. The output is registered and 0
//    outside DONE.
//  - err_count width N_IN+1 holds the maximum 2**N_IN without wrap.
//    idx does not wrap within a run.
//  - start and sample_valid in the same cycle while in DONE: start wins and the
//    sample is dropped.
//  - Back-to-back samples on every cycle are supported. Gaps of any length are
//    allowed.
// TESTING (EXPECTED=16'h6996, N_IN=4)
//  1 reset, start, then 16 samples with vec=0..15 and f=^vec -> done=1, pass=1,
//    err_count=0, first_err_vld=0, order_err=0. busy is high for exactly the
//    run span.
//  2 same run, but vec=5 gives f=1 (expected 0) and vec=12 gives f=1 -> err_count=2,
//    first_err_idx=5, first_err_vld=1, pass=0.
//  3 drive all f inverted -> err_count=16 (5'b10000, no wrap), first_err_idx=0, pass=0.
//  4 vec=3 sent twice, then vec=5..15 (16 samples total) -> order_err=1 and
//    pass=0, even if every f matches.
//  5 assert reset after 8 samples -> next cycle busy=0 and all outputs 0. Then
//    start and run a clean sequence -> pass=1.
//  6 start pulsed during RUN, and sample_valid held in IDLE/DONE -> both are
//    ignored. After DONE, a second start clears the results and a rerun passes.

Source files
------------

// File: rtl/truth_table_checker.sv
// Response checker for exhaustive combinational tests. It compares each applied vector's
// observed output against a golden truth table and accumulates a verdict per run.
module truth_table_checker #(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 16'h6996
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sample_valid,
  input  logic [N_IN-1:0] vec,
  input  logic            f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_vld,
  output logic            order_err
);

  // state  | meaning
  // S_IDLE | out of reset, waiting for the first start
  // S_RUN  | accepting samples, idx tracks the expected vector
  // S_DONE | run finished, results held until the next start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [N_IN:0] ONE      = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

  state_t          state, state_nxt;
  logic [N_IN:0]   idx;
  logic            accept, begin_run, last_sample;
  logic            mismatch, order_fault;
  logic            pass_nxt;

  assign accept      = (state == S_RUN) && sample_valid;
  assign begin_run   = start && (state != S_RUN);
  assign last_sample = accept && (idx == LAST_IDX);
  assign mismatch    = (f != EXPECTED[vec]);
  assign order_fault = ({1'b0, vec} != idx);
  // The verdict has to include the last sample, which only lands in the registers this edge.
  assign pass_nxt    = (err_count == '0) && !mismatch && !order_err && !order_fault;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)       state_nxt = S_RUN;
      S_RUN:   if (last_sample) state_nxt = S_DONE;
      S_DONE:  if (start)       state_nxt = S_RUN;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || begin_run) begin
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      order_err     <= 1'b0;
      pass          <= 1'b0;
    end else if (accept) begin
      idx <= idx + ONE;
      if (mismatch) begin
        err_count <= err_count + ONE;
        if (!first_err_vld) begin
          first_err_idx <= vec;
          first_err_vld <= 1'b1;
        end
      end
      if (order_fault) order_err <= 1'b1;
      if (last_sample) pass <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a run-level reference model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] vec = '0;
  logic       f = 1'b0;
  logic       busy, done, pass, first_err_vld, order_err;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_tab = 16'h6996;

  // Reference: phase of the run plus the list of samples accepted in it.
  int         m_phase = 0;  // 0 idle, 1 running, 2 finished
  int         m_n     = 0;
  logic [3:0] m_vec [16];
  logic       m_f   [16];

  truth_table_checker dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .vec(vec), .f(f), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_vld(first_err_vld), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = 0;
      m_n = 0;
    end else if (m_phase != 1 && start) begin
      m_phase = 1;
      m_n = 0;
    end else if (m_phase == 1 && sample_valid) begin
      m_vec[m_n] = vec;
      m_f[m_n]   = f;
      m_n++;
      if (m_n == 16) m_phase = 2;
    end
  endtask

  task automatic compare_all();
    int   e_err   = 0;
    int   e_first = 0;
    logic e_fvld  = 1'b0;
    logic e_ord   = 1'b0;
    logic e_done;
    for (int i = 0; i < m_n; i++) begin
      if (m_f[i] != exp_tab[m_vec[i]]) begin
        if (!e_fvld) e_first = int'(m_vec[i]);
        e_fvld = 1'b1;
        e_err++;
      end
      if (int'(m_vec[i]) != i) e_ord = 1'b1;
    end
    e_done = (m_phase == 2);
    check("busy",          busy,          (m_phase == 1));
    check("done",          done,          e_done);
    check("pass",          pass,          e_done && e_err == 0 && !e_ord);
    check("err_count",     err_count,     e_err);
    check("first_err_idx", first_err_idx, e_first);
    check("first_err_vld", first_err_vld, e_fvld);
    check("order_err",     order_err,     e_ord);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input logic fv);
    sample_valid = 1'b1; vec = v; f = fv; cyc(); sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clean_run(input int gap);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v, ^v);
      if (gap > 0 && i[0]) idle(gap);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_err",  err_count, 0);

    // 1: clean back-to-back run
    idle(2);
    pulse_start();
    clean_run(0);
    idle(2);
    check("t1_pass", pass, 1);
    check("t1_err",  err_count, 0);
    check("t1_done", done, 1);

    // 2: two wrong vectors, with gaps between samples
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v, (^v) ^ (i == 5 || i == 12));
      if (i[0]) idle(i % 3);
    end
    idle(1);
    check("t2_err",   err_count, 2);
    check("t2_first", first_err_idx, 5);
    check("t2_fvld",  first_err_vld, 1);
    check("t2_pass",  pass, 0);

    // 3: every output inverted, counter must reach 16 without wrapping
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v, ~(^v));
    end
    idle(1);
    check("t3_err",   err_count, 16);
    check("t3_first", first_err_idx, 0);
    check("t3_pass",  pass, 0);

    // 4: vector 3 repeated, 4 skipped; outputs all correct
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = (i <= 3) ? 4'(i) : (i == 4) ? 4'd3 : 4'(i);
      send(v, ^v);
    end
    idle(1);
    check("t4_order", order_err, 1);
    check("t4_err",   err_count, 0);
    check("t4_pass",  pass, 0);
    check("t4_done",  done, 1);

    // 5: reset mid-run, then a clean run
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v, ~(^v));
    end
    do_reset();
    check("t5_busy", busy, 0);
    check("t5_err",  err_count, 0);
    check("t5_fvld", first_err_vld, 0);
    pulse_start();
    clean_run(1);
    idle(1);
    check("t5_pass", pass, 1);

    // 6: samples ignored outside a run, start ignored inside one
    do_reset();
    sample_valid = 1'b1; vec = 4'd0; f = 1'b1;
    idle(3);
    sample_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      if (i == 4) pulse_start();
      if (i == 9) begin
        start = 1'b1; send(v, ^v); start = 1'b0;
      end else begin
        send(v, ^v);
      end
    end
    check("t6_pass_a", pass, 1);
    sample_valid = 1'b1; vec = 4'd0; f = 1'b1;
    idle(3);
    start = 1'b1; cyc(); start = 1'b0;
    sample_valid = 1'b0;
    check("t6_cleared", done, 0);
    clean_run(0);
    idle(1);
    check("t6_pass_b", pass, 1);
    check("t6_err",    err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
